// File: rtl/prng_sched.sv
// prng_sched: shares an AES-CTR PRNG among NUM_REQ requesters (key load, warm-up mask, round-robin grants, per-key word budget)
module prng_sched #(
    parameter int NUM_REQ     = 2,
    parameter int KEY_WIDTH   = 128,
    parameter int AES_LATENCY = 10,
    parameter int WORD_LIMIT  = 65536
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [KEY_WIDTH-1:0] cfg_key,
    input  logic                 cfg_key_valid,
    output logic                 prng_load_key,
    output logic [KEY_WIDTH-1:0] prng_key,
    output logic                 prng_rst,
    input  logic [255:0]         prng_word,
    input  logic [NUM_REQ-1:0]   req,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [255:0]         rnd_word,
    output logic                 rnd_valid,
    output logic                 ready,
    output logic                 reseed_req
);
    localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
    localparam int IW = $clog2(WORD_LIMIT + 1);
    localparam int WW = $clog2(AES_LATENCY + 1);
    typedef enum logic [2:0] {NOKEY, LOAD, WARMUP, RUN, EXHAUSTED} state_t;
    state_t        state;
    logic [WW-1:0] warm;
    logic [IW-1:0] issued;
    logic [PW-1:0] ptr;
    logic [PW-1:0] win;
    logic [PW-1:0] idx;
    logic          hit;
    always_comb begin
        win = ptr;
        idx = ptr;
        hit = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = PW'((int'(ptr) + i) % NUM_REQ);
            if (!hit && req[idx]) begin
                win = idx;
                hit = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= NOKEY;
            warm          <= '0;
            issued        <= '0;
            ptr           <= PW'(NUM_REQ - 1);
            prng_key      <= '0;
            prng_load_key <= 1'b0;
            prng_rst      <= 1'b0;
            gnt           <= '0;
            rnd_word      <= '0;
            rnd_valid     <= 1'b0;
            ready         <= 1'b0;
            reseed_req    <= 1'b0;
        end else if (cfg_key_valid) begin
            state         <= LOAD;
            prng_key      <= cfg_key;
            issued        <= '0;
            prng_load_key <= 1'b1;
            prng_rst      <= 1'b1;
            gnt           <= '0;
            rnd_valid     <= 1'b0;
            ready         <= 1'b0;
            reseed_req    <= 1'b0;
        end else begin
            prng_load_key <= 1'b0;
            prng_rst      <= 1'b0;
            gnt           <= '0;
            rnd_valid     <= 1'b0;
            case (state)
                LOAD: begin
                    state <= WARMUP;
                    warm  <= '0;
                end
                WARMUP: begin
                    warm <= warm + WW'(1);
                    if (warm == WW'(AES_LATENCY - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (hit && issued < IW'(WORD_LIMIT)) begin
                        gnt       <= NUM_REQ'(1) << win;
                        rnd_word  <= prng_word;
                        rnd_valid <= 1'b1;
                        ptr       <= win;
                        issued    <= issued + IW'(1);
                        if (issued == IW'(WORD_LIMIT - 1)) begin
                            state      <= EXHAUSTED;
                            ready      <= 1'b0;
                            reseed_req <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
